// File: rtl/cve2_pkg.sv
// Shared types and constants for the cve2 EX-stage MAC accumulate unit.
package cve2_pkg;

  typedef enum logic [1:0] {
    MAC_IDLE     = 2'd0,
    MAC_MUL_WAIT = 2'd1,
    MAC_ADD      = 2'd2,
    MAC_WB       = 2'd3
  } mac_acc_state_e;

  // Clamp values for a 32-bit signed accumulate result.
  localparam logic [31:0] MAC_SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] MAC_SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/cve2_mac_sat.sv
// Signed-overflow detect and clamp for the MAC accumulate add (a + b = sum).
module cve2_mac_sat #(
  parameter int unsigned DataWidth = 32
) (
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [DataWidth-1:0] sum_i,
  output logic [DataWidth-1:0] result_o,
  output logic                 sat_o
);

  localparam logic [DataWidth-1:0] SatMax = {1'b0, {(DataWidth-1){1'b1}}};
  localparam logic [DataWidth-1:0] SatMin = {1'b1, {(DataWidth-1){1'b0}}};

  // Overflow only when both addends share a sign that the sum lost.
  function automatic logic ovf_detect(input logic signed [DataWidth-1:0] a,
                                      input logic signed [DataWidth-1:0] b,
                                      input logic signed [DataWidth-1:0] s);
    return (a[DataWidth-1] == b[DataWidth-1]) && (s[DataWidth-1] != a[DataWidth-1]);
  endfunction

  function automatic logic [DataWidth-1:0] sat_clamp(input logic signed [DataWidth-1:0] a,
                                                     input logic signed [DataWidth-1:0] s,
                                                     input logic                       ovf);
    if (!ovf) return s;
    return a[DataWidth-1] ? SatMin : SatMax;
  endfunction

  logic signed [DataWidth-1:0] a_s, b_s, sum_s;

  assign a_s      = a_i;
  assign b_s      = b_i;
  assign sum_s    = sum_i;
  assign sat_o    = ovf_detect(a_s, b_s, sum_s);
  assign result_o = sat_clamp(a_s, sum_s, sat_o);

endmodule

// File: rtl/cve2_mac_acc_unit.sv
// MAC accumulate unit: latches acc operand and product, drives the ALU adder, holds the sum for WB.
// Define CVE2_MAC_SAT_EN to enable signed saturation of the accumulate result (sat_o).
module cve2_mac_acc_unit
  import cve2_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mac_start_i,
  input  logic [DataWidth-1:0] acc_operand_i,
  input  logic                 mul_valid_i,
  input  logic [DataWidth-1:0] mul_result_i,
  input  logic [DataWidth-1:0] alu_result_i,
  input  logic                 flush_i,
  input  logic                 wb_ready_i,
  output logic                 alu_sel_o,
  output logic [DataWidth-1:0] alu_operand_a_o,
  output logic [DataWidth-1:0] alu_operand_b_o,
  output logic                 mac_valid_o,
  output logic [DataWidth-1:0] mac_result_o,
  output logic                 busy_o,
  output logic                 sat_o
);

  mac_acc_state_e state_q, state_d;

  logic [DataWidth-1:0] acc_q, prod_q, res_q, res_d;
  logic                 acc_en, prod_en, res_en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MAC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over every other event and leaves the data registers untouched.
  always_comb begin
    state_d = state_q;
    acc_en  = 1'b0;
    prod_en = 1'b0;
    res_en  = 1'b0;
    if (flush_i) begin
      state_d = MAC_IDLE;
    end else begin
      unique case (state_q)
        MAC_IDLE: begin
          if (mac_start_i) begin
            acc_en  = 1'b1;
            state_d = MAC_MUL_WAIT;
          end
        end
        MAC_MUL_WAIT: begin
          if (mul_valid_i) begin
            prod_en = 1'b1;
            state_d = MAC_ADD;
          end
        end
        MAC_ADD: begin
          res_en  = 1'b1;
          state_d = MAC_WB;
        end
        MAC_WB: begin
          if (wb_ready_i) state_d = MAC_IDLE;
        end
        default: state_d = MAC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      prod_q <= '0;
      res_q  <= '0;
    end else begin
      if (acc_en)  acc_q  <= acc_operand_i;
      if (prod_en) prod_q <= mul_result_i;
      if (res_en)  res_q  <= res_d;
    end
  end

`ifdef CVE2_MAC_SAT_EN
  logic sat_d, sat_q;

  cve2_mac_sat #(
    .DataWidth (DataWidth)
  ) u_mac_sat (
    .a_i      (prod_q),
    .b_i      (acc_q),
    .sum_i    (alu_result_i),
    .result_o (res_d),
    .sat_o    (sat_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_q <= 1'b0;
    end else if (res_en) begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = (state_q == MAC_WB) && sat_q;
`else
  assign res_d = alu_result_i;
  assign sat_o = 1'b0;
`endif

  always_comb begin
    alu_sel_o       = 1'b0;
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    mac_valid_o     = 1'b0;
    mac_result_o    = '0;
    busy_o          = 1'b0;
    unique case (state_q)
      MAC_MUL_WAIT: busy_o = 1'b1;
      MAC_ADD: begin
        busy_o          = 1'b1;
        alu_sel_o       = 1'b1;
        alu_operand_a_o = prod_q;
        alu_operand_b_o = acc_q;
      end
      MAC_WB: begin
        busy_o       = !wb_ready_i;
        mac_valid_o  = 1'b1;
        mac_result_o = res_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cve2_mac_acc_unit.sv
// Scoreboard bench for cve2_mac_acc_unit; the ALU is an adder driven from the DUT operand outputs.
module tb_cve2_mac_acc_unit;
  import cve2_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        mac_start_i;
  logic [31:0] acc_operand_i;
  logic        mul_valid_i;
  logic [31:0] mul_result_i;
  logic [31:0] alu_result_i;
  logic        flush_i;
  logic        wb_ready_i;
  logic        alu_sel_o;
  logic [31:0] alu_operand_a_o;
  logic [31:0] alu_operand_b_o;
  logic        mac_valid_o;
  logic [31:0] mac_result_o;
  logic        busy_o;
  logic        sat_o;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  // Outside the MAC ADD phase the ALU is busy with unrelated work.
  assign alu_result_i = alu_sel_o ? (alu_operand_a_o + alu_operand_b_o) : 32'hDEAD_BEEF;

  cve2_mac_acc_unit #(.DataWidth(32)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .mac_start_i     (mac_start_i),
    .acc_operand_i   (acc_operand_i),
    .mul_valid_i     (mul_valid_i),
    .mul_result_i    (mul_result_i),
    .alu_result_i    (alu_result_i),
    .flush_i         (flush_i),
    .wb_ready_i      (wb_ready_i),
    .alu_sel_o       (alu_sel_o),
    .alu_operand_a_o (alu_operand_a_o),
    .alu_operand_b_o (alu_operand_b_o),
    .mac_valid_o     (mac_valid_o),
    .mac_result_o    (mac_result_o),
    .busy_o          (busy_o),
    .sat_o           (sat_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {sat, result} for acc + prod.
  function automatic logic [32:0] mac_model(input logic [31:0] acc, input logic [31:0] prod);
    logic [31:0] s;
    logic        sat;
    s   = acc + prod;
    sat = 1'b0;
`ifdef CVE2_MAC_SAT_EN
    if ((prod[31] == acc[31]) && (s[31] != prod[31])) begin
      sat = 1'b1;
      s   = prod[31] ? MAC_SAT_MIN : MAC_SAT_MAX;
    end
`endif
    return {sat, s};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_mac(input logic [31:0] acc, input logic [31:0] prod, input int k,
                        input int stall, input bit poke_add, input bit flush_wb);
    logic [32:0] exp;
    int          vcyc;
    vcyc          = -1;
    mac_start_i   = 1'b1;
    acc_operand_i = acc;
    exp_q.push_back(mac_model(acc, prod));
    for (int c = 1; c <= k + 10 && vcyc < 0; c++) begin
      @(negedge clk_i);
      mac_start_i   = 1'b0;
      acc_operand_i = $urandom;
      mul_valid_i   = (c == k);
      mul_result_i  = (c == k) ? prod : $urandom;
      if (c == k + 1) begin
        chk("add_sel", 32'(alu_sel_o), 32'd1);
        chk("add_opa", alu_operand_a_o, prod);
        chk("add_opb", alu_operand_b_o, acc);
        if (poke_add) mac_start_i = 1'b1;
      end else if (c <= k) begin
        chk("wait_sel", 32'(alu_sel_o), 32'd0);
      end
      if (mac_valid_o) vcyc = c;
      else chk("busy_run", 32'(busy_o), 32'd1);
    end
    mul_valid_i = 1'b0;
    mac_start_i = 1'b0;
    exp = exp_q.pop_front();
    if (vcyc < 0) begin
      chk("valid_timeout", 32'd0, 32'd1);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      return;
    end
    chk("latency", 32'(vcyc), 32'(k + 2));
    chk("result", mac_result_o, exp[31:0]);
    chk("sat", 32'(sat_o), 32'(exp[32]));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_i);
      chk("hold_valid", 32'(mac_valid_o), 32'd1);
      chk("hold_result", mac_result_o, exp[31:0]);
      chk("hold_busy", 32'(busy_o), 32'd1);
    end
    if (flush_wb) begin
      flush_i = 1'b1;
    end else begin
      wb_ready_i = 1'b1;
      #1 chk("busy_ready", 32'(busy_o), 32'd0);
    end
    @(negedge clk_i);
    wb_ready_i = 1'b0;
    flush_i    = 1'b0;
    chk("idle_valid", 32'(mac_valid_o), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_result", mac_result_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni        = 1'b0;
    mac_start_i   = 1'b0;
    acc_operand_i = '0;
    mul_valid_i   = 1'b0;
    mul_result_i  = '0;
    flush_i       = 1'b0;
    wb_ready_i    = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(mac_valid_o), 32'd0);
    chk("rst_sel", 32'(alu_sel_o), 32'd0);
    chk("rst_opa", alu_operand_a_o, 32'd0);
    chk("rst_result", mac_result_o, 32'd0);
    chk("rst_sat", 32'(sat_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Basic, slow multiplier, backpressure
    do_mac(32'd5, 32'd12, 1, 0, 1'b0, 1'b0);
    do_mac(32'd100, 32'hFFFF_FFF6, 4, 0, 1'b0, 1'b0);
    do_mac(32'h1234_5678, 32'h0000_1111, 2, 3, 1'b0, 1'b0);

    // Flush in MUL_WAIT, then a stray mul_valid while idle
    mac_start_i   = 1'b1;
    acc_operand_i = 32'h0BAD_0BAD;
    @(negedge clk_i);
    mac_start_i = 1'b0;
    chk("fl_mw_busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("fl_mw_idle", 32'(busy_o), 32'd0);
    chk("fl_mw_valid", 32'(mac_valid_o), 32'd0);
    mul_valid_i  = 1'b1;
    mul_result_i = 32'h5555_5555;
    @(negedge clk_i);
    mul_valid_i = 1'b0;
    chk("mulv_idle_busy", 32'(busy_o), 32'd0);
    chk("mulv_idle_sel", 32'(alu_sel_o), 32'd0);

    // Flush beats start in the same cycle
    mac_start_i = 1'b1;
    flush_i     = 1'b1;
    @(negedge clk_i);
    mac_start_i = 1'b0;
    flush_i     = 1'b0;
    chk("fl_start_busy", 32'(busy_o), 32'd0);

    // Flush in WB, then normal operation resumes; start poked during ADD
    do_mac(32'd7, 32'd8, 1, 1, 1'b0, 1'b1);
    do_mac(32'd40, 32'd2, 3, 0, 1'b1, 1'b0);

    // Async reset mid-operation
    mac_start_i   = 1'b1;
    acc_operand_i = 32'd9;
    @(negedge clk_i);
    mac_start_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_valid", 32'(mac_valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Overflow cases: positive, negative, and no-overflow opposite signs
    do_mac(32'h2000_0000, 32'h7000_0000, 1, 0, 1'b0, 1'b0);
    do_mac(32'h8000_0000, 32'h8000_0001, 2, 1, 1'b0, 1'b0);
    do_mac(32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_mac($urandom, $urandom, 1 + (i % 4), i % 3, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cve2_mac_acc_unit.md
Name: cve2_mac_acc_unit

Overview:
- Downstream companion of the MAC sequencing controller in the cve2 EX stage.
- Collects the multiplier product for a MAC instruction and latches the accumulator operand (rd old value).
- Steers both values onto the ALU adder inputs during the ADD phase, then captures the sum.
- Holds the sum in a result register until writeback accepts it, with optional signed saturation.

Parameters:
DataWidth, 32, width of operands, product and result

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
mac_start_i  in  1  single-cycle start pulse from MAC controller (multiplier enable rising)
acc_operand_i  in  DataWidth  accumulator operand, sampled with mac_start_i
mul_valid_i  in  1  multiplier result valid
mul_result_i  in  DataWidth  low word of multiplier product
alu_result_i  in  DataWidth  ALU adder result
flush_i  in  1  pipeline kill (exception/branch), aborts operation
wb_ready_i  in  1  writeback accepts result
alu_sel_o  out  1  overrides ALU operand muxes with alu_operand_a_o/b_o
alu_operand_a_o  out  DataWidth  product to ALU
alu_operand_b_o  out  DataWidth  accumulator to ALU
mac_valid_o  out  1  result available
mac_result_o  out  DataWidth  final MAC result
busy_o  out  1  operation in progress (stall request to ID)
sat_o  out  1  result was saturated (valid with mac_valid_o)

Behaviour:
- Reset: state IDLE; all outputs 0; acc_q, prod_q, res_q cleared to 0.
- FSM states: IDLE, MUL_WAIT, ADD, WB (enum, 2 bits).
- IDLE: on mac_start_i && !flush_i, latch acc_q <= acc_operand_i, go to MUL_WAIT. Otherwise stay in IDLE.
- MUL_WAIT: on mul_valid_i, latch prod_q <= mul_result_i, go to ADD. Otherwise hold.
- ADD, one cycle:
  - alu_sel_o=1, alu_operand_a_o=prod_q, alu_operand_b_o=acc_q.
  - res_q <= alu_result_i, or the saturated value when the feature is enabled.
  - Go to WB.
- WB:
  - mac_valid_o=1, mac_result_o=res_q.
  - On wb_ready_i, go to IDLE. Else hold, with result stable.
- alu_operand_a_o/b_o are driven 0 and alu_sel_o=0 outside ADD.
- mac_result_o is 0 when not in WB.
- busy_o is 1 in MUL_WAIT, ADD, and in WB while !wb_ready_i; it is 0 in IDLE.
- Latency: start in cycle 0, mul_valid_i in cycle k (k≥1) → ADD in cycle k+1 → mac_valid_o in cycle k+2. Minimum is 3 cycles start-to-valid.
- mac_start_i outside IDLE is ignored; no queuing.
- mul_valid_i outside MUL_WAIT is ignored.
- flush_i in any state: next state IDLE, no mac_valid_o; registers keep stale data.
  - Flush has priority over mac_start_i, mul_valid_i and wb_ready_i in the same cycle.
- WB with wb_ready_i and mac_start_i in the same cycle: return to IDLE; the start is dropped. The controller must not issue back-to-back MACs without one IDLE cycle.
- Arithmetic: two's-complement DataWidth add performed by the ALU. Product is the low word only, with no carry-in.
- Asynchronous reset mid-operation: immediate return to IDLE, outputs 0.

Optional Feature:
- Macro: CVE2_MAC_SAT_EN.
- Defined:
  - Signed overflow is detected as sign(prod_q)==sign(acc_q) && sign(alu_result_i)!=sign(prod_q).
  - Positive overflow clamps to 0x7FFF_FFFF; negative overflow clamps to 0x8000_0000.
  - The sat flag is registered alongside res_q and shown on sat_o in WB.
- Undefined: wrap-around result; sat_o tied 0.

Decomposition:
- cve2_pkg: mac_acc_state_e enum; MAC_SAT_MAX / MAC_SAT_MIN constants (DataWidth=32).
- Sub-module cve2_mac_sat: combinational overflow detect plus clamp (inputs a, b, sum; outputs result, sat). Instantiated only under CVE2_MAC_SAT_EN.

Test Plan:
- Basic: acc=5, start, mul_valid 1 cycle later with product 12, ALU returns 17 → mac_result_o=17, mac_valid_o in cycle 3, sat_o=0, alu_operand_a/b=12/5 during ADD.
- Slow multiplier: mul_valid_i delayed 4 cycles → busy_o high throughout, mac_valid_o at cycle 6, result correct.
- Backpressure: wb_ready_i low 3 cycles in WB → mac_valid_o and mac_result_o held stable, busy_o=1, then IDLE one cycle after ready.
- Flush: flush_i in MUL_WAIT and separately in WB → IDLE next cycle, mac_valid_o never or no longer asserted; a later start works normally.
- Saturation (SAT_EN): prod=0x7000_0000, acc=0x2000_0000, ALU 0x9000_0000 → result 0x7FFF_FFFF, sat_o=1. Without the macro → 0x9000_0000, sat_o=0.
- Ignored events: mac_start_i during ADD and mul_valid_i in IDLE → no state change, no corruption of the in-flight result.
